// File: rtl/mem_lock_arbiter_if.sv
// Bundle of the SIC memory lock/request signals shared between the
// requesting memory sub-SICs, the data memory and the lock arbiter.
interface mem_lock_arbiter_if #(
    parameter int NUM_SICS = 4,
    parameter int ID_WIDTH = 6
);
    logic [ID_WIDTH-1:0]          head_id;
    logic [NUM_SICS-1:0]          req;
    logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id;
    logic [NUM_SICS-1:0]          release_lock;
    logic [NUM_SICS*30-1:0]       req_addr;
    logic [NUM_SICS*32-1:0]       req_wdata;
    logic [NUM_SICS-1:0]          req_wen;
    logic [NUM_SICS-1:0]          grant;
    logic [31:0]                  rdata;
    logic [29:0]                  mem_addr;
    logic [31:0]                  mem_wdata;
    logic                         mem_wen;
    logic [31:0]                  mem_rdata;
    logic                         locked;

    // Requester/memory side: drives requests and memory read data.
    modport master (
        output head_id, req, req_issue_id, release_lock, req_addr,
               req_wdata, req_wen, mem_rdata,
        input  grant, rdata, mem_addr, mem_wdata, mem_wen, locked
    );

    // Arbiter side.
    modport slave (
        input  head_id, req, req_issue_id, release_lock, req_addr,
               req_wdata, req_wen, mem_rdata,
        output grant, rdata, mem_addr, mem_wdata, mem_wen, locked
    );
endinterface

// File: rtl/mem_lock_arbiter.sv
// Lock arbiter for the shared data-memory port. Grants the lock to the
// oldest requester by issue-ID age (relative to head_id), holds it until the
// owner releases or drops its request, and hands it off with no bubble.
module mem_lock_arbiter #(
    parameter int  NUM_SICS = 4,
    parameter int  ID_WIDTH = 6,
    localparam int OWNER_W  = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_lock_arbiter_if.slave io_bus
);
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t               r_state;
    logic [OWNER_W-1:0]   r_owner;

    logic [NUM_SICS*ID_WIDTH-1:0] w_keys;
    logic [NUM_SICS-1:0]          w_mask_excl;
    logic [OWNER_W:0]             w_pick_all;
    logic [OWNER_W:0]             w_pick_excl;
    logic                         w_owner_req;
    logic                         w_free;
    logic                         w_locked;

    // Returns {found, index} of the set mask bit with the smallest age key;
    // strict compare keeps the lowest index on ties.
    function automatic logic [OWNER_W:0] pick_oldest(
        input logic [NUM_SICS-1:0]          mask,
        input logic [NUM_SICS*ID_WIDTH-1:0] keys
    );
        logic               found;
        logic [OWNER_W-1:0] idx;
        logic [ID_WIDTH-1:0] best;
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            if (mask[i] && (!found || keys[i*ID_WIDTH +: ID_WIDTH] < best)) begin
                found = 1'b1;
                best  = keys[i*ID_WIDTH +: ID_WIDTH];
                idx   = OWNER_W'(i);
            end
        end
        return {found, idx};
    endfunction

    // Age keys (modular distance from head), winners and the free condition.
    always_comb begin
        w_keys = '0;
        for (int i = 0; i < NUM_SICS; i++) begin
            w_keys[i*ID_WIDTH +: ID_WIDTH] =
                io_bus.req_issue_id[i*ID_WIDTH +: ID_WIDTH] - io_bus.head_id;
        end
        w_mask_excl = io_bus.req & ~(NUM_SICS'(1) << r_owner);
        w_pick_all  = pick_oldest(io_bus.req, w_keys);
        w_pick_excl = pick_oldest(w_mask_excl, w_keys);
        w_locked    = (r_state == S_LOCKED);
        w_owner_req = io_bus.req[r_owner];
        w_free      = w_locked && (io_bus.release_lock[r_owner] || !w_owner_req);
    end

    // Lock FSM: arbitrate in IDLE, hold while locked, hand off on free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_all[OWNER_W]) begin
                        r_owner <= w_pick_all[OWNER_W-1:0];
                        r_state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_free) begin
                        if (w_pick_excl[OWNER_W]) begin
                            r_owner <= w_pick_excl[OWNER_W-1:0];
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant follows the owner's request only while the lock is held.
    always_comb begin
        io_bus.grant = '0;
        if (w_locked) begin
            io_bus.grant[r_owner] = w_owner_req;
        end
    end

    // Memory port always mirrors the owner; writes gated by lock and request.
    assign io_bus.mem_addr  = io_bus.req_addr[int'(r_owner)*30 +: 30];
    assign io_bus.mem_wdata = io_bus.req_wdata[int'(r_owner)*32 +: 32];
    assign io_bus.mem_wen   = w_locked & w_owner_req & io_bus.req_wen[r_owner];
    assign io_bus.rdata     = io_bus.mem_rdata;
    assign io_bus.locked    = w_locked;

endmodule
